rf_write_arbiter: RTL and testbench

// Shares the single register-file write port (regWrite/writeRegister/writeData)

---
 rtl/rf_write_arbiter_if.sv | 30 +++
 rtl/rf_write_arbiter.sv | 82 ++++++++
 tb/tb_rf_write_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Writeback request bus and register-file write port shared by the requesters and the arbiter.
// The pend_* signals mirror the output stage and are read by hazard/forwarding logic.
interface rf_write_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               rf_regWrite;
    logic [AW-1:0]      rf_writeReg;
    logic [DW-1:0]      rf_writeData;
    logic               pend_valid;
    logic [AW-1:0]      pend_addr;
    logic [2:0]         grant_idx;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, rf_regWrite, rf_writeReg, rf_writeData,
        input  pend_valid, pend_addr, grant_idx
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, rf_regWrite, rf_writeReg, rf_writeData,
        output pend_valid, pend_addr, grant_idx
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among NREQ writeback sources.
// One registered output stage; writes to register 0 complete the handshake but are never committed.
module rf_write_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input logic clk,
    input logic rst,
    rf_write_arbiter_if.slave bus
);
    logic [2:0]      rrPtr;
    logic [NREQ-1:0] reqReady;
    logic            grantHit;
    logic [2:0]      grantSel;
    logic [AW-1:0]   selAddr;
    logic [DW-1:0]   selData;
    logic            regWrite;
    logic [AW-1:0]   writeReg;
    logic [DW-1:0]   writeData;
    logic [2:0]      grantIdx;
    int              scanIdx;

    // Scan starting at rrPtr; the inner compare keeps every select index a constant.
    always_comb begin
        grantHit = 1'b0;
        grantSel = '0;
        scanIdx  = 0;
        for (int k = 0; k < NREQ; k++) begin
            scanIdx = (int'(rrPtr) + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!grantHit && (i == scanIdx) && bus.req_valid[i]) begin
                    grantHit = 1'b1;
                    grantSel = 3'(i);
                end
            end
        end
    end

    always_comb begin
        reqReady = '0;
        selAddr  = '0;
        selData  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grantHit && (int'(grantSel) == i)) begin
                reqReady[i] = 1'b1;
                selAddr     = bus.req_addr[i*AW +: AW];
                selData     = bus.req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtr     <= '0;
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
            grantIdx  <= '0;
        end else if (grantHit) begin
            if (int'(grantSel) == NREQ - 1) begin
                rrPtr <= '0;
            end else begin
                rrPtr <= grantSel + 3'd1;
            end
            regWrite  <= (selAddr != '0);
            writeReg  <= selAddr;
            writeData <= selData;
            grantIdx  <= grantSel;
        end else begin
            regWrite <= 1'b0;
        end
    end

    assign bus.req_ready    = reqReady;
    assign bus.rf_regWrite  = regWrite;
    assign bus.rf_writeReg  = writeReg;
    assign bus.rf_writeData = writeData;
    assign bus.pend_valid   = regWrite;
    assign bus.pend_addr    = writeReg;
    assign bus.grant_idx    = grantIdx;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: a transaction-level model checked against the DUT every cycle,
// plus directed scenarios with literal expectations on grants and register-file contents.
module tb_rf_write_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic started = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [NREQ-1:0] reqValid = '0;
    logic [AW-1:0]   reqAddr [NREQ];
    logic [DW-1:0]   reqData [NREQ];

    // Model state: pointer, expected output stage, grant history.
    int            mPtr = 0;
    logic          mWe = 1'b0;
    logic [AW-1:0] mReg = '0;
    logic [DW-1:0] mData = '0;
    int            mGidx = 0;
    int            grantLog[$];

    logic [DW-1:0] tbRf [32] = '{default: '0};

    rf_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.req_valid = reqValid;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*AW +: AW] = reqAddr[i];
            bus.req_data[i*DW +: DW] = reqData[i];
        end
    end

    // Register file fed by the DUT's write port.
    always @(posedge clk) begin
        if (!rst && bus.rf_regWrite) tbRf[bus.rf_writeReg] <= bus.rf_writeData;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic int modelGrant(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mPtr = 0; mWe = 1'b0; mReg = '0; mData = '0; mGidx = 0;
    endtask

    // Compare on the falling edge, advance the model on the rising edge.
    initial begin
        int g;
        logic [NREQ-1:0] expReady;
        forever begin
            @(negedge clk);
            if (rst) modelReset();
            if (started) begin
                g = modelGrant(reqValid, mPtr);
                expReady = '0;
                if (g >= 0) expReady[g] = 1'b1;
                chk("req_ready", 64'(bus.req_ready), 64'(expReady));
                chk("rf_regWrite", 64'(bus.rf_regWrite), 64'(mWe));
                chk("rf_writeReg", 64'(bus.rf_writeReg), 64'(mReg));
                chk("rf_writeData", 64'(bus.rf_writeData), 64'(mData));
                chk("grant_idx", 64'(bus.grant_idx), 64'(mGidx));
                chk("pend_valid", 64'(bus.pend_valid), 64'(mWe));
                chk("pend_addr", 64'(bus.pend_addr), 64'(mReg));
            end
            @(posedge clk);
            if (rst) begin
                modelReset();
            end else begin
                g = modelGrant(reqValid, mPtr);
                if (g >= 0) begin
                    grantLog.push_back(g);
                    mReg  = reqAddr[g];
                    mData = reqData[g];
                    mWe   = (reqAddr[g] != '0);
                    mGidx = g;
                    mPtr  = (g + 1) % NREQ;
                end else begin
                    mWe = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            reqAddr[i] = '0;
            reqData[i] = '0;
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        started = 1'b1;
        #1;
        chk("reset_regWrite", 64'(bus.rf_regWrite), 64'd0);
        chk("reset_writeData", 64'(bus.rf_writeData), 64'd0);
        chk("reset_grant_idx", 64'(bus.grant_idx), 64'd0);

        // Single write from requester 1.
        reqAddr[1] = 5'd7; reqData[1] = 32'hDEADBEEF; reqValid = 3'b010;
        #1;
        chk("single_ready", 64'(bus.req_ready), 64'h2);
        step();
        reqValid = '0;
        chk("single_regWrite", 64'(bus.rf_regWrite), 64'd1);
        chk("single_writeReg", 64'(bus.rf_writeReg), 64'd7);
        step();
        chk("single_rf7", 64'(tbRf[7]), 64'hDEADBEEF);

        // Async reset while a write is in flight.
        reqAddr[0] = 5'd3; reqData[0] = 32'h55; reqValid = 3'b001;
        step();
        chk("pre_reset_regWrite", 64'(bus.rf_regWrite), 64'd1);
        rst = 1'b1;
        reqValid = '0;
        #1;
        chk("async_regWrite", 64'(bus.rf_regWrite), 64'd0);
        chk("async_writeReg", 64'(bus.rf_writeReg), 64'd0);
        chk("async_writeData", 64'(bus.rf_writeData), 64'd0);
        chk("async_pend_valid", 64'(bus.pend_valid), 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("reset_dropped_rf3", 64'(tbRf[3]), 64'd0);

        // Rotation: all requesters valid for six cycles from reset.
        reqAddr[0] = 5'd10; reqData[0] = 32'h100;
        reqAddr[1] = 5'd11; reqData[1] = 32'h101;
        reqAddr[2] = 5'd12; reqData[2] = 32'h102;
        grantLog.delete();
        reqValid = 3'b111;
        repeat (6) step();
        reqValid = '0;
        chk("rot_count", 64'(grantLog.size()), 64'd6);
        for (int i = 0; i < 6 && i < grantLog.size(); i++)
            chk($sformatf("rot_order%0d", i), 64'(grantLog[i]), 64'(i % 3));
        step();
        chk("rot_rf12", 64'(tbRf[12]), 64'h102);

        // Wrap/skip: park pointer at 2, then requesters 0 and 1.
        grantLog.delete();
        reqValid = 3'b010;
        step();
        reqValid = 3'b011;
        #1;
        chk("wrap_ready0", 64'(bus.req_ready), 64'h1);
        #1;
        step();
        reqValid = 3'b010;
        #1;
        chk("wrap_ready1", 64'(bus.req_ready), 64'h2);
        #1;
        step();
        reqValid = '0;
        chk("wrap_ptr", 64'(mPtr), 64'd2);
        chk("wrap_log1", 64'(grantLog[1]), 64'd0);
        chk("wrap_log2", 64'(grantLog[2]), 64'd1);
        reqValid = 3'b111;
        #1;
        chk("wrap_ptr_dut", 64'(bus.req_ready), 64'h4);
        #1;
        step();
        reqValid = '0;

        // Register 0: handshake completes, nothing committed, pointer advances.
        reqAddr[0] = 5'd0; reqData[0] = 32'h12345678; reqValid = 3'b001;
        #1;
        chk("zero_ready", 64'(bus.req_ready), 64'h1);
        #1;
        step();
        reqValid = '0;
        chk("zero_regWrite", 64'(bus.rf_regWrite), 64'd0);
        chk("zero_pend_valid", 64'(bus.pend_valid), 64'd0);
        reqValid = 3'b011;
        #1;
        chk("zero_ptr_adv", 64'(bus.req_ready), 64'h2);
        #1;
        step();
        reqValid = '0;
        step();
        chk("zero_rf0", 64'(tbRf[0]), 64'd0);

        // Same destination from two requesters in one cycle.
        reqAddr[2] = 5'd20; reqData[2] = 32'h7;
        reqValid = 3'b100;
        step();
        reqAddr[0] = 5'd5; reqData[0] = 32'hA;
        reqAddr[1] = 5'd5; reqData[1] = 32'hB;
        reqValid = 3'b011;
        step();
        reqValid = 3'b010;
        step();
        reqValid = '0;
        chk("conflict_first", 64'(tbRf[5]), 64'hA);
        step();
        chk("conflict_final", 64'(tbRf[5]), 64'hB);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
